// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
interface instr_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;

  // Loader side: consumes bytes, drives memory writes.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  // Source side: supplies bytes, observes memory writes.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/instr_loader.sv
// Program loader: assembles a big-endian byte stream into 16-bit words and
// writes them into instruction memory until a HLT word or the memory end.
module instr_loader #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  instr_loader_if.slave     bus,
  output logic [ADDR_W:0]   word_count,
  output logic              exec,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {StIdle, StHi, StLo, StWrite, StDone, StErr} state_e;

  localparam logic [ADDR_W-1:0] AddrOne  = 1;
  localparam logic [ADDR_W:0]   CountOne = 1;

  state_e            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        lo_q, lo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              is_hlt;
  logic              at_last;

  // HLT: top two bits of the high byte set and upper nibble of the low byte set.
  assign is_hlt  = (hi_q[7:6] == 2'b11) && (lo_q[7:4] == 4'hF);
  assign at_last = &addr_q;

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    addr_d  = addr_q;
    count_d = count_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StHi;
          addr_d  = '0;
          count_d = '0;
        end
      end
      StHi: begin
        if (bus.in_valid) begin
          hi_d    = bus.in_data;
          state_d = StLo;
        end
      end
      StLo: begin
        if (bus.in_valid) begin
          lo_d    = bus.in_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
        count_d = count_q + CountOne;
        if (is_hlt) begin
          state_d = StDone;
        end else if (at_last) begin
          // No wrap-around: the address stays on the last word.
          state_d = StErr;
        end else begin
          addr_d  = addr_q + AddrOne;
          state_d = StHi;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    bus.in_ready   = (state_q == StHi) || (state_q == StLo);
    bus.imem_we    = (state_q == StWrite);
    bus.imem_addr  = addr_q;
    bus.imem_wdata = {hi_q, lo_q};
    word_count     = count_q;
    done           = (state_q == StDone);
    exec           = (state_q == StDone);
    error          = (state_q == StErr);
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with a write scoreboard.
module tb_instr_loader;
  localparam int unsigned AW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   word_count;
  logic          exec;
  logic          done;
  logic          error;

  instr_loader_if #(.ADDR_W(AW)) bus ();

  instr_loader #(.ADDR_W(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .word_count (word_count),
    .exec       (exec),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  checks    = 0;
  int  failures  = 0;
  int  we_pulses = 0;

  // Count every cycle the write strobe is high.
  always @(posedge clock) begin
    if (bus.imem_we === 1'b1) we_pulses <= we_pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic settle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Offer a byte until accepted; after a low byte the write must appear next cycle.
  task automatic send_byte(input logic [7:0] b, input bit is_lo);
    int  n;
    wr_t e;
    n = 0;
    @(negedge clock);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("handshake_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    if (is_lo) begin
      chk("we_latency", {31'd0, bus.imem_we}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", {30'd0, bus.imem_addr}, {30'd0, e.addr});
        chk("wr_data", {16'd0, bus.imem_wdata}, {16'd0, e.data});
      end
    end
  endtask

  task automatic send_word(input logic [15:0] w, input logic [AW-1:0] a, input int gap);
    exp_q.push_back('{addr: a, data: w});
    send_byte(w[15:8], 1'b0);
    idle(gap);
    send_byte(w[7:0], 1'b1);
  endtask

  // Pulse start and confirm the loader is waiting for a high byte with counters cleared.
  task automatic begin_load();
    @(negedge clock);
    start = 1'b1;
    settle();
    start = 1'b0;
    chk("start_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("start_done", {31'd0, done}, 32'd0);
    chk("start_exec", {31'd0, exec}, 32'd0);
    chk("start_error", {31'd0, error}, 32'd0);
    chk("start_count", {29'd0, word_count}, 32'd0);
    chk("start_addr", {30'd0, bus.imem_addr}, 32'd0);
  endtask

  task automatic chk_end(input string tag, input bit exp_done, input bit exp_err,
                         input int exp_count, input int exp_pulses);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    chk({tag, "_exec"}, {31'd0, exec}, {31'd0, exp_done});
    chk({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
    chk({tag, "_count"}, {29'd0, word_count}, exp_count);
    chk({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_pulses"}, we_pulses, exp_pulses);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_we"}, {31'd0, bus.imem_we}, 32'd0);
    chk({tag, "_addr"}, {30'd0, bus.imem_addr}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, bus.imem_wdata}, 32'd0);
    chk({tag, "_count"}, {29'd0, word_count}, 32'd0);
    chk({tag, "_flags"}, {29'd0, exec, done, error}, 32'd0);
  endtask

  initial begin
    int p0;
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    chk_reset_vals("reset");
    @(negedge clock);
    reset = 1'b0;

    // in_valid in IDLE must not consume a byte.
    bus.in_data  = 8'hAA;
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    chk("idle_valid_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("idle_valid_wdata", {16'd0, bus.imem_wdata}, 32'd0);
    chk("idle_valid_count", {29'd0, word_count}, 32'd0);

    // Basic load, with start pulsed in HI and in LO.
    p0 = we_pulses;
    begin_load();
    @(negedge clock);
    start = 1'b1;
    settle();
    start = 1'b0;
    chk("start_in_hi_ready", {31'd0, bus.in_ready}, 32'd1);
    exp_q.push_back('{addr: 2'd0, data: 16'h8005});
    send_byte(8'h80, 1'b0);
    @(negedge clock);
    start = 1'b1;
    settle();
    start = 1'b0;
    send_byte(8'h05, 1'b1);
    send_word(16'hC0F0, 2'd1, 0);
    settle();
    chk_end("basic", 1'b1, 1'b0, 2, p0 + 2);
    chk("basic_addr_hold", {30'd0, bus.imem_addr}, 32'd1);

    // Restart from DONE with a NOP first.
    p0 = we_pulses;
    begin_load();
    send_word(16'h0000, 2'd0, 0);
    send_word(16'hC0F0, 2'd1, 0);
    settle();
    chk_end("restart", 1'b1, 1'b0, 2, p0 + 2);

    // Gapped byte stream.
    p0 = we_pulses;
    begin_load();
    idle(2);
    send_word(16'h8005, 2'd0, 3);
    idle(4);
    send_word(16'hC0F0, 2'd1, 2);
    settle();
    chk_end("gaps", 1'b1, 1'b0, 2, p0 + 2);

    // Near-miss HLT patterns are ordinary words; 0xFFFF is HLT.
    p0 = we_pulses;
    begin_load();
    send_word(16'hC0E0, 2'd0, 0);
    send_word(16'h80F0, 2'd1, 0);
    send_word(16'hFFFF, 2'd2, 0);
    settle();
    chk_end("nearmiss", 1'b1, 1'b0, 3, p0 + 3);

    // Overflow: four non-HLT words fill memory.
    p0 = we_pulses;
    begin_load();
    for (int i = 0; i < 4; i++) send_word(16'(i + 1), 2'(i), 0);
    settle();
    chk_end("overflow", 1'b0, 1'b1, 4, p0 + 4);
    chk("overflow_addr_hold", {30'd0, bus.imem_addr}, 32'd3);
    @(negedge clock);
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    chk("err_hold_error", {31'd0, error}, 32'd1);
    chk("err_hold_pulses", we_pulses, p0 + 4);

    // HLT at the last address wins over overflow.
    p0 = we_pulses;
    begin_load();
    for (int i = 0; i < 3; i++) send_word(16'(i + 1), 2'(i), 0);
    send_word(16'hC0F0, 2'd3, 0);
    settle();
    chk_end("hlt_last", 1'b1, 1'b0, 4, p0 + 4);

    // Reset in LO with a low byte offered in the same cycle.
    p0 = we_pulses;
    begin_load();
    send_byte(8'hC0, 1'b0);
    @(negedge clock);
    reset        = 1'b1;
    start        = 1'b1;
    bus.in_data  = 8'hF0;
    bus.in_valid = 1'b1;
    settle();
    chk_reset_vals("midreset");
    @(negedge clock);
    reset        = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    settle();
    chk_reset_vals("midreset_after");
    chk("midreset_pulses", we_pulses, p0);
    begin_load();
    send_word(16'h1234, 2'd0, 0);
    send_word(16'hC0F0, 2'd1, 1);
    settle();
    chk_end("reload", 1'b1, 1'b0, 2, p0 + 2);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
